// File: rtl/gpu_cmd_scheduler.sv
// Two-port GPU command scheduler: arbitrates requesters into a small FIFO and issues
// queued commands to the gpu over a submit/ready handshake. Define GPU_ARB_RR_EN for round-robin.
module gpu_cmd_scheduler #(
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0_valid,
    input  logic [3:0]               req0_cmd,
    input  logic [15:0]              req0_offset,
    input  logic [7:0]               req0_x,
    input  logic [7:0]               req0_y,
    input  logic [7:0]               req0_length,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic [3:0]               req1_cmd,
    input  logic [15:0]              req1_offset,
    input  logic [7:0]               req1_x,
    input  logic [7:0]               req1_y,
    input  logic [7:0]               req1_length,
    output logic                     req1_ready,
    output logic [3:0]               gpu_cmd,
    output logic [15:0]              gpu_draw_offset,
    output logic [7:0]               gpu_draw_x,
    output logic [7:0]               gpu_draw_y,
    output logic [7:0]               gpu_draw_length,
    output logic                     gpu_cmd_submitted,
    input  logic                     gpu_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy,
    output logic                     err_timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 44;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_ACK  = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [1:0]    state;
    logic [7:0]    ack_cnt;
    logic          full;
    logic          empty;
    logic          grant0;
    logic          grant1;
    logic          push;
    logic          pop;
    logic [EW-1:0] push_data;
    logic [EW-1:0] head;

    // A full FIFO refuses both ports even if a pop happens in the same cycle.
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign push      = grant0 | grant1;
    assign pop       = (state == ST_IDLE) && !empty && gpu_ready;
    assign push_data = grant0 ? {req0_cmd, req0_offset, req0_x, req0_y, req0_length}
                              : {req1_cmd, req1_offset, req1_x, req1_y, req1_length};
    assign head      = mem[rd_ptr];

`ifdef GPU_ARB_RR_EN
    logic rr_ptr;  // port preferred on the next conflict

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!full) begin
            if (req0_valid && req1_valid) begin
                grant0 = !rr_ptr;
                grant1 = rr_ptr;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= 1'b0;
        else if (push)
            rr_ptr <= grant0;
    end
`else
    always_comb begin
        grant0 = req0_valid && !full;
        grant1 = req1_valid && !req0_valid && !full;
    end
`endif

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // NOTE: the storage array is not reset; count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_IDLE;
            ack_cnt           <= '0;
            gpu_cmd           <= '0;
            gpu_draw_offset   <= '0;
            gpu_draw_x        <= '0;
            gpu_draw_y        <= '0;
            gpu_draw_length   <= '0;
            gpu_cmd_submitted <= 1'b0;
            err_timeout       <= 1'b0;
        end else begin
            gpu_cmd_submitted <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        {gpu_cmd, gpu_draw_offset, gpu_draw_x, gpu_draw_y, gpu_draw_length} <= head;
                        gpu_cmd_submitted <= 1'b1;
                        ack_cnt           <= '0;
                        state             <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    // A gpu that never drops ready is abandoned; the command is not retried.
                    if (!gpu_ready) begin
                        state <= ST_WAIT_DONE;
                    end else if (ack_cnt == 8'(ACK_TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        ack_cnt <= ack_cnt + 8'd1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (gpu_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign fifo_count = count;
    assign busy       = !empty || (state != ST_IDLE);

endmodule
